// File: rtl/mdu_hilo_if.sv
//--------------------------------------------------------------------------
// mdu_hilo_if -- issue/result bundle between the execute stage and mdu_hilo
// Rev 1.0
//--------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface mdu_hilo_if;
  logic        W_start;
  logic [2:0]  W_op;
  logic [31:0] W_rs_data;
  logic [31:0] W_rt_data;
  logic        W_flush;
  logic        R_busy;
  logic        R_done;
  logic [31:0] R_hi;
  logic [31:0] R_lo;

  modport master (
    output W_start, W_op, W_rs_data, W_rt_data, W_flush,
    input  R_busy, R_done, R_hi, R_lo
  );

  modport slave (
    input  W_start, W_op, W_rs_data, W_rt_data, W_flush,
    output R_busy, R_done, R_hi, R_lo
  );
endinterface

`default_nettype wire

// File: rtl/mdu_hilo.sv
//--------------------------------------------------------------------------
// mdu_hilo -- multi-cycle MULT/DIV unit owning the architectural HI/LO pair
// Rev 1.0
//--------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mdu_hilo #(
  parameter int unsigned MUL_LATENCY = 1,
  parameter logic [31:0] HILO_RESET  = 32'h0000_0000
) (
  input wire logic  clk,
  input wire logic  rst,
  mdu_hilo_if.slave bus
);

  localparam logic [2:0] C_OP_MULT  = 3'd0;
  localparam logic [2:0] C_OP_MULTU = 3'd1;
  localparam logic [2:0] C_OP_DIV   = 3'd2;
  localparam logic [2:0] C_OP_DIVU  = 3'd3;
  localparam logic [2:0] C_OP_MTHI  = 3'd4;
  localparam logic [2:0] C_OP_MTLO  = 3'd5;
  localparam logic [4:0] C_MUL_LAST = 5'(MUL_LATENCY - 1);
  localparam logic [4:0] C_DIV_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic [4:0]  r_cnt;
  logic [31:0] r_rs;
  logic [31:0] r_rt;
  logic        r_signed;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dsr;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_accept;
  logic        w_acc_mul;
  logic        w_acc_div;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_mul_wr;
  logic        w_div_wr;
  logic        w_iter;
  logic        w_op_signed;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_mul    = 1'b0;
    w_acc_div    = 1'b0;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    w_mul_wr     = 1'b0;
    w_div_wr     = 1'b0;
    w_iter       = 1'b0;
    w_accept     = bus.W_start && (r_state == S_IDLE) && !bus.W_flush &&
                   (bus.W_op <= C_OP_MTLO);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((bus.W_op == C_OP_MULT) || (bus.W_op == C_OP_MULTU)) begin
            w_acc_mul    = 1'b1;
            w_state_next = S_MUL;
          end else if ((bus.W_op == C_OP_DIV) || (bus.W_op == C_OP_DIVU)) begin
            w_acc_div    = 1'b1;
            w_state_next = S_DIV;
          end else if (bus.W_op == C_OP_MTHI) begin
            w_mthi = 1'b1;
          end else begin
            w_mtlo = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_cnt == C_MUL_LAST) begin
          w_mul_wr     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_DIV: begin
        w_iter = 1'b1;
        if (r_cnt == C_DIV_LAST) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_div_wr     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A squash beats any completion that would land on the same edge.
    if (bus.W_flush) begin
      w_state_next = S_IDLE;
      w_mul_wr     = 1'b0;
      w_div_wr     = 1'b0;
      w_iter       = 1'b0;
    end
  end

  // --------------------------------------------------------------- datapath
  assign w_op_signed = (bus.W_op == C_OP_MULT) || (bus.W_op == C_OP_DIV);
  assign w_rs_mag    = (w_op_signed && bus.W_rs_data[31]) ? (32'd0 - bus.W_rs_data)
                                                          : bus.W_rs_data;
  assign w_rt_mag    = (w_op_signed && bus.W_rt_data[31]) ? (32'd0 - bus.W_rt_data)
                                                          : bus.W_rt_data;

  // Low 64 bits of the extended product are exact for both signednesses.
  assign w_mul_a = {{32{r_signed & r_rs[31]}}, r_rs};
  assign w_mul_b = {{32{r_signed & r_rt[31]}}, r_rt};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  assign w_ge    = ~w_diff[32];

  assign w_q_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi     <= HILO_RESET;
      r_lo     <= HILO_RESET;
      r_done   <= 1'b0;
      r_cnt    <= 5'd0;
      r_rs     <= 32'd0;
      r_rt     <= 32'd0;
      r_signed <= 1'b0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dsr    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_acc_mul || w_acc_div) begin
        r_cnt    <= 5'd0;
        r_rs     <= bus.W_rs_data;
        r_rt     <= bus.W_rt_data;
        r_signed <= w_op_signed;
        r_quo    <= w_rs_mag;
        r_rem    <= 32'd0;
        r_dsr    <= w_rt_mag;
        r_neg_q  <= w_op_signed & (bus.W_rs_data[31] ^ bus.W_rt_data[31]);
        r_neg_r  <= w_op_signed & bus.W_rs_data[31];
      end else if ((r_state == S_MUL) || w_iter) begin
        r_cnt <= r_cnt + 5'd1;
      end

      // One restoring step: dividend bits shift out of r_quo into r_rem.
      if (w_iter) begin
        r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
        r_quo <= {r_quo[30:0], w_ge};
      end

      if (w_mthi) begin
        r_hi <= bus.W_rs_data;
      end
      if (w_mtlo) begin
        r_lo <= bus.W_rs_data;
      end

      if (w_mul_wr) begin
        r_hi   <= w_prod[63:32];
        r_lo   <= w_prod[31:0];
        r_done <= 1'b1;
      end

      if (w_div_wr) begin
        if (r_dsr == 32'd0) begin
          r_hi <= r_rs;
          r_lo <= 32'hFFFF_FFFF;
        end else begin
          r_hi <= w_r_fix;
          r_lo <= w_q_fix;
        end
        r_done <= 1'b1;
      end
    end
  end

  assign bus.R_busy = (r_state != S_IDLE);
  assign bus.R_done = r_done;
  assign bus.R_hi   = r_hi;
  assign bus.R_lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
//--------------------------------------------------------------------------
// tb_mdu_hilo -- directed self-checking bench for mdu_hilo
// Rev 1.0
//--------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mdu_hilo;

  localparam int unsigned C_LAT   = 2;
  localparam logic [31:0] C_RST_V = 32'h5A5A_0F0F;
  localparam logic [2:0]  C_MULT  = 3'd0;
  localparam logic [2:0]  C_MULTU = 3'd1;
  localparam logic [2:0]  C_DIV   = 3'd2;
  localparam logic [2:0]  C_DIVU  = 3'd3;
  localparam logic [2:0]  C_MTHI  = 3'd4;
  localparam logic [2:0]  C_MTLO  = 3'd5;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mdu_hilo_if bus ();

  mdu_hilo #(
    .MUL_LATENCY (C_LAT),
    .HILO_RESET  (C_RST_V)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.W_start   = 1'b1;
    bus.W_op      = op;
    bus.W_rs_data = rs;
    bus.W_rt_data = rt;
    tick();
    bus.W_start   = 1'b0;
  endtask

  // Counts remaining busy cycles from the current cycle, then checks the done pulse.
  task automatic run_to_done(input string tag, input int exp_busy);
    int n;
    n = 0;
    while ((bus.R_busy === 1'b1) && (n < 200)) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    chk({tag, "_done"}, {31'd0, bus.R_done}, 32'd1);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, bus.R_done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.R_busy}, 32'd0);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.R_done === 1'b1) seen = 1'b1;
      tick();
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.W_start   = 1'b0;
    bus.W_op      = 3'd0;
    bus.W_rs_data = 32'd0;
    bus.W_rt_data = 32'd0;
    bus.W_flush   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_hi", bus.R_hi, C_RST_V);
    chk("rst_lo", bus.R_lo, C_RST_V);
    chk("rst_busy", {31'd0, bus.R_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.R_done}, 32'd0);

    // MULT -2 * 3
    issue(C_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hold_hi", bus.R_hi, C_RST_V);
    run_to_done("mult", C_LAT);
    chk("mult_hi", bus.R_hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.R_lo, 32'hFFFF_FFFA);

    // MULTU same operands
    issue(C_MULTU, 32'hFFFF_FFFE, 32'd3);
    run_to_done("multu", C_LAT);
    chk("multu_hi", bus.R_hi, 32'd2);
    chk("multu_lo", bus.R_lo, 32'hFFFF_FFFA);

    // DIV -7 / 2
    issue(C_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_hold_hi", bus.R_hi, 32'd2);
    chk("div_hold_lo", bus.R_lo, 32'hFFFF_FFFA);
    run_to_done("div", 33);
    chk("div_lo", bus.R_lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.R_hi, 32'hFFFF_FFFF);

    // DIVU 100 / 7
    issue(C_DIVU, 32'd100, 32'd7);
    run_to_done("divu", 33);
    chk("divu_lo", bus.R_lo, 32'd14);
    chk("divu_hi", bus.R_hi, 32'd2);

    // Divide by zero
    issue(C_DIVU, 32'h1234_1234, 32'd0);
    run_to_done("divz", 33);
    chk("divz_lo", bus.R_lo, 32'hFFFF_FFFF);
    chk("divz_hi", bus.R_hi, 32'h1234_1234);

    // Signed overflow
    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_to_done("ovf", 33);
    chk("ovf_lo", bus.R_lo, 32'h8000_0000);
    chk("ovf_hi", bus.R_hi, 32'd0);

    // MTHI then MTLO back to back
    bus.W_start   = 1'b1;
    bus.W_op      = C_MTHI;
    bus.W_rs_data = 32'hAAAA_5555;
    tick();
    chk("mthi_hi", bus.R_hi, 32'hAAAA_5555);
    chk("mthi_busy", {31'd0, bus.R_busy}, 32'd0);
    bus.W_op      = C_MTLO;
    bus.W_rs_data = 32'h1234_1234;
    tick();
    bus.W_start   = 1'b0;
    chk("mtlo_lo", bus.R_lo, 32'h1234_1234);
    chk("mtlo_hi_kept", bus.R_hi, 32'hAAAA_5555);
    chk("mtlo_busy", {31'd0, bus.R_busy}, 32'd0);
    chk("mtlo_done", {31'd0, bus.R_done}, 32'd0);

    // Reserved opcode is ignored
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    chk("rsvd_busy", {31'd0, bus.R_busy}, 32'd0);
    chk("rsvd_hi", bus.R_hi, 32'hAAAA_5555);

    // Second start while busy is ignored
    issue(C_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 4; i++) tick();
    bus.W_start   = 1'b1;
    bus.W_op      = C_DIVU;
    bus.W_rs_data = 32'd50;
    bus.W_rt_data = 32'd0;
    tick();
    bus.W_start   = 1'b0;
    run_to_done("busy_start", 28);
    chk("busy_start_lo", bus.R_lo, 32'd14);
    chk("busy_start_hi", bus.R_hi, 32'd2);
    watch_no_done("busy_start_no_second", 40);

    // Flush at busy cycle 10
    issue(C_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    bus.W_flush = 1'b1;
    tick();
    bus.W_flush = 1'b0;
    chk("flush_busy", {31'd0, bus.R_busy}, 32'd0);
    chk("flush_hi", bus.R_hi, 32'd2);
    chk("flush_lo", bus.R_lo, 32'd14);
    watch_no_done("flush_no_done", 40);
    chk("flush_hi_later", bus.R_hi, 32'd2);

    // Flush and start together in IDLE
    bus.W_flush = 1'b1;
    issue(C_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("fs_mthi_hi", bus.R_hi, 32'd2);
    issue(C_DIV, 32'd9, 32'd3);
    bus.W_flush = 1'b0;
    chk("fs_div_busy", {31'd0, bus.R_busy}, 32'd0);

    // Reset at busy cycle 20
    issue(C_DIV, 32'd77, 32'd5);
    for (int i = 0; i < 19; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_hi", bus.R_hi, C_RST_V);
    chk("rst_mid_lo", bus.R_lo, C_RST_V);
    chk("rst_mid_busy", {31'd0, bus.R_busy}, 32'd0);
    watch_no_done("rst_mid_no_done", 40);

    issue(C_MULT, 32'd6, 32'd7);
    run_to_done("mult67", C_LAT);
    chk("mult67_hi", bus.R_hi, 32'd0);
    chk("mult67_lo", bus.R_lo, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
